// File: rtl/sp_ram_bist.sv
// -----------------------------------------------------------------------------
// sp_ram_bist
//   Built-in self test for a single-port RAM. On start it writes NUM_WORDS
//   pseudo-random words (32-bit Galois LFSR, x^32+x^22+x^2+x+1) to addresses
//   0..NUM_WORDS-1, then replays the same LFSR sequence and compares every
//   read-back word against it. Read data arrives READ_LATENCY cycles after the
//   address, so the expected word and its address ride a matching pipeline.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   start           : test request, honoured only in IDLE and DONE
//   busy            : high during WRITE, READ and DRAIN
//   done            : high in DONE
//   pass            : high in DONE when no compare failed
//   mismatch_count  : saturating count of failing compares
//   first_fail_addr : address of the first failing compare
//   ram_data        : write data to the RAM
//   ram_addr        : address to the RAM
//   ram_we          : write enable to the RAM
//   ram_q           : read data from the RAM
// -----------------------------------------------------------------------------
module sp_ram_bist #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_WIDTH   = 10,
   parameter int          NUM_WORDS    = 32,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] SEED         = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           mismatch_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [31:0]           SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
   // Right-shift Galois tap mask: bit (e-1) set for each term x^e, e = 32,22,2,1.
   localparam logic [31:0]           TAPS       = 32'h8020_0003;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : 32'd0);
   endfunction

   state_t                  state;
   logic [31:0]             lfsr;      // pattern for the next beat
   logic [DATA_WIDTH-1:0]   exp_cur;   // expected word for the read on ram_addr
   logic                    rd_valid;  // ram_addr currently carries a read
   logic [1:0]              drain_cnt;

   // Expected word / address pipeline, aligned with the RAM read latency.
   logic [READ_LATENCY-1:0] pipe_v;
   logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];
   logic [ADDR_WIDTH-1:0]   pipe_a [READ_LATENCY];

   logic                    hit;
   logic [15:0]             mm_next;

   assign hit = pipe_v[READ_LATENCY-1] && (ram_q !== pipe_d[READ_LATENCY-1]);

   always_comb begin
      // NOTE: assign a default before any condition so no path holds the old
      // value combinationally, which would infer a latch.
      mm_next = mismatch_count;
      if (hit && (mismatch_count != 16'hFFFF))
         mm_next = mismatch_count + 16'd1;
   end

   // NOTE: pure datapath registers carry no reset; only the valid bits need
   // one, and leaving the wide payload unreset keeps it out of the reset tree.
   always_ff @(posedge clk) begin
      pipe_d[0] <= exp_cur;
      pipe_a[0] <= ram_addr;
      for (int k = 1; k < READ_LATENCY; k++) begin
         pipe_d[k] <= pipe_d[k-1];
         pipe_a[k] <= pipe_a[k-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         lfsr            <= SEED_EFF;
         exp_cur         <= '0;
         rd_valid        <= 1'b0;
         drain_cnt       <= '0;
         pipe_v          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         mismatch_count  <= '0;
         first_fail_addr <= '0;
         ram_data        <= '0;
         ram_addr        <= '0;
         ram_we          <= 1'b0;
      end else begin
         pipe_v[0] <= rd_valid;
         for (int k = 1; k < READ_LATENCY; k++)
            pipe_v[k] <= pipe_v[k-1];

         // Count never wraps, so a zero count marks the first failure.
         if (hit) begin
            mismatch_count <= mm_next;
            if (mismatch_count == 16'd0)
               first_fail_addr <= pipe_a[READ_LATENCY-1];
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= WRITE;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  mismatch_count  <= '0;
                  first_fail_addr <= '0;
                  ram_we          <= 1'b1;
                  ram_addr        <= '0;
                  ram_data        <= SEED_EFF[DATA_WIDTH-1:0];
                  lfsr            <= lfsr_next(SEED_EFF);
               end
            end

            WRITE: begin
               if (ram_addr == LAST_ADDR) begin
                  state    <= READ;
                  ram_we   <= 1'b0;
                  ram_data <= '0;
                  ram_addr <= '0;
                  rd_valid <= 1'b1;
                  exp_cur  <= SEED_EFF[DATA_WIDTH-1:0];
                  lfsr     <= lfsr_next(SEED_EFF);
               end else begin
                  ram_addr <= ram_addr + 1'b1;
                  ram_data <= lfsr[DATA_WIDTH-1:0];
                  lfsr     <= lfsr_next(lfsr);
               end
            end

            READ: begin
               if (ram_addr == LAST_ADDR) begin
                  state     <= DRAIN;
                  rd_valid  <= 1'b0;
                  ram_addr  <= '0;
                  drain_cnt <= '0;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
                  exp_cur  <= lfsr[DATA_WIDTH-1:0];
                  lfsr     <= lfsr_next(lfsr);
               end
            end

            DRAIN: begin
               // The last read compares on the edge that leaves DRAIN, so the
               // verdict is taken from the post-compare count.
               if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (mm_next == 16'd0);
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sp_ram_bist.md
SP_RAM_BIST -- requirements
Module: sp_ram_bist

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: RAM word width, 1..32.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: RAM address width.
REQ-003 The block SHALL have parameter NUM_WORDS, default 32: words tested, addresses 0..NUM_WORDS-1, 1..2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1: cycles from ram_addr presented to ram_q valid, 1..4.
REQ-005 The block SHALL have parameter SEED, default 32'hACE1_2468: LFSR start value; a value of 0 SHALL be replaced by 1.
REQ-006 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1: test request, sampled in IDLE and DONE.
REQ-009 The block SHALL have port busy, output, 1: high during WRITE, READ and DRAIN.
REQ-010 The block SHALL have port done, output, 1: high in DONE.
REQ-011 The block SHALL have port pass, output, 1: high in DONE when mismatch_count==0.
REQ-012 The block SHALL have port mismatch_count, output, 16: compare failures, saturating at 16'hFFFF.
REQ-013 The block SHALL have port first_fail_addr, output, ADDR_WIDTH: address of the first failing compare.
REQ-014 The block SHALL have port ram_data, output, DATA_WIDTH: write data to the RAM.
REQ-015 The block SHALL have port ram_addr, output, ADDR_WIDTH: address to the RAM.
REQ-016 The block SHALL have port ram_we, output, 1: RAM write enable.
REQ-017 The block SHALL have port ram_q, input, DATA_WIDTH: RAM read data.

Function
REQ-018 The block SHALL drive all outputs from registers.
REQ-019 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE.
REQ-020 On the edge E0 where start=1 is sampled in IDLE or DONE, the FSM SHALL go to WRITE, reload the LFSR with SEED, clear mismatch_count, first_fail_addr and the address counter, and drop done and pass.
REQ-021 The LFSR SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, and pattern word = LFSR[DATA_WIDTH-1:0].
REQ-022 WRITE: for cycles 1..NUM_WORDS after E0, ram_we=1, ram_addr=i and ram_data=pattern i (i from 0), where pattern 0 = SEED; the LFSR SHALL advance once per beat.
REQ-023 After the last write beat, the FSM SHALL enter READ, reload the LFSR with SEED and set ram_we=0.
REQ-024 READ: for cycles NUM_WORDS+1..2*NUM_WORDS, ram_addr=i; the expected word and address SHALL travel through a READ_LATENCY-deep pipeline.
REQ-025 Read i SHALL be compared (ram_q !== expected, full width) on edge E0+NUM_WORDS+1+i+READ_LATENCY.
REQ-026 A mismatch SHALL increment mismatch_count, saturating at 16'hFFFF; on the first mismatch only, first_fail_addr SHALL capture the address.
REQ-027 DRAIN SHALL last READ_LATENCY cycles, with no address issued and ram_we=0.
REQ-028 After the final compare, the FSM SHALL enter DONE with done=1, busy=0 and pass=(mismatch_count==0).
REQ-029 The result SHALL hold until start or rst.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 start held high in DONE SHALL restart the test immediately.
REQ-032 In IDLE, DONE and DRAIN, ram_we, ram_addr and ram_data SHALL be 0.

Reset
REQ-033 While rst=1, the block SHALL go to IDLE immediately, regardless of clock, and hold all outputs at 0, including busy, done, pass, mismatch_count, first_fail_addr, ram_we, ram_addr and ram_data.
REQ-034 Reset during any state SHALL abort the test, with no partial result retained.
REQ-035 After rst is released, the block SHALL stay in IDLE until start.

Verification
REQ-036 Scenario: defaults with a behavioural sp_ram (registered read, latency 1), start pulsed one cycle -> 32 write beats with addr 0..31, the first ram_data = 32'hACE1_2468, then 32 reads; done rises after edge E0+65; pass=1, mismatch_count=0.
REQ-037 Scenario: ram_q bit 0 inverted only when the returned address is 5 -> mismatch_count=1, first_fail_addr=5, pass=0.
REQ-038 Scenario: ram_q forced to 0 throughout -> mismatch_count=32, first_fail_addr=0, pass=0 (SEED pattern nonzero for every word).
REQ-039 Scenario: rst asserted asynchronously mid-WRITE at address 10 -> all outputs 0 before the next clock edge; a subsequent start completes with pass=1.
REQ-040 Scenario: start pulsed during READ -> no effect, done timing unchanged; start held high through DONE -> done high for exactly one cycle, then a new run begins with mismatch_count cleared.
